// File: rtl/sap_ctrl_seq_var_if.sv
// Control-sequencer bus: IR opcode and zero flag in, SAP control word, halt flag and T-state out.
interface sap_ctrl_seq_var_if #(
  parameter int RING_LEN = 6
);
  logic [3:0]          opcode;
  logic                Zero;
  logic                Cp, Ep, EA, SU, EU;
  logic                LMbar, CEbar, LIbar, EIbar, LAbar, LBbar, LObar, LPbar;
  logic                Halt;
  logic [RING_LEN-1:0] Tstate;

  modport master (
    input  opcode, Zero,
    output Cp, Ep, EA, SU, EU,
    output LMbar, CEbar, LIbar, EIbar, LAbar, LBbar, LObar, LPbar,
    output Halt, Tstate
  );

  modport slave (
    output opcode, Zero,
    input  Cp, Ep, EA, SU, EU,
    input  LMbar, CEbar, LIbar, EIbar, LAbar, LBbar, LObar, LPbar,
    input  Halt, Tstate
  );
endinterface

// File: rtl/sap_ctrl_seq_var.sv
// SAP-1 control sequencer: falling-edge one-hot ring counter plus live microcode decode.
// Optional early end-of-instruction is enabled by defining SAP_EARLY_END_EN.
module sap_ctrl_seq_var #(
  parameter int         RING_LEN = 6,
  parameter logic [3:0] OP_LDA   = 4'b0000,
  parameter logic [3:0] OP_ADD   = 4'b0001,
  parameter logic [3:0] OP_SUB   = 4'b0010,
  parameter logic [3:0] OP_JMP   = 4'b0100,
  parameter logic [3:0] OP_JZ    = 4'b0101,
  parameter logic [3:0] OP_OUT   = 4'b1110,
  parameter logic [3:0] OP_HLT   = 4'b1111
) (
  input logic                Clk,
  input logic                Clrbar,
  sap_ctrl_seq_var_if.master bus
);

  if (RING_LEN < 6 || RING_LEN > 16) begin : g_bad_ring_len
    $fatal(1, "sap_ctrl_seq_var: RING_LEN=%0d outside legal range 6..16", RING_LEN);
  end

  typedef enum logic {S_RUN, S_HALT} state_t;

  localparam logic [RING_LEN-1:0] T1_OH = RING_LEN'(1);
  localparam logic [RING_LEN-1:0] T4_OH = RING_LEN'(8);

  state_t              r_state, w_state_nxt;
  logic [RING_LEN-1:0] r_tstate, w_tstate_nxt;

`ifdef SAP_EARLY_END_EN
  // One-hot mask of the final T-state of each instruction.
  function automatic logic [RING_LEN-1:0] last_mask(input logic [3:0] op);
    logic [RING_LEN-1:0] m;
    m = '0;
    case (op)
      OP_LDA:                 m[4] = 1'b1;
      OP_ADD, OP_SUB:         m[5] = 1'b1;
      OP_OUT, OP_JMP, OP_JZ:  m[3] = 1'b1;
      default:                m[2] = 1'b1;
    endcase
    return m;
  endfunction

  logic w_last_hit;
  assign w_last_hit = |(r_tstate & last_mask(bus.opcode));
`endif

  always_ff @(negedge Clk or negedge Clrbar) begin
    if (!Clrbar) begin
      r_state  <= S_RUN;
      r_tstate <= T1_OH;
    end else begin
      r_state  <= w_state_nxt;
      r_tstate <= w_tstate_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_tstate_nxt = r_tstate;
    if (r_state == S_RUN) begin
      if (r_tstate[2] && bus.opcode == OP_HLT) begin
        w_state_nxt  = S_HALT;
        w_tstate_nxt = T4_OH;
      end else begin
        w_tstate_nxt = {r_tstate[RING_LEN-2:0], r_tstate[RING_LEN-1]};
`ifdef SAP_EARLY_END_EN
        if (w_last_hit) w_tstate_nxt = T1_OH;
`endif
      end
    end
  end

  // Reset gates the decode so the control word goes inactive without waiting for a clock.
  always_comb begin
    bus.Cp    = 1'b0;
    bus.Ep    = 1'b0;
    bus.EA    = 1'b0;
    bus.SU    = 1'b0;
    bus.EU    = 1'b0;
    bus.LMbar = 1'b1;
    bus.CEbar = 1'b1;
    bus.LIbar = 1'b1;
    bus.EIbar = 1'b1;
    bus.LAbar = 1'b1;
    bus.LBbar = 1'b1;
    bus.LObar = 1'b1;
    bus.LPbar = 1'b1;
    if (Clrbar && r_state == S_RUN) begin
      if (r_tstate[0]) begin
        bus.Ep    = 1'b1;
        bus.LMbar = 1'b0;
      end
      if (r_tstate[1]) bus.Cp = 1'b1;
      if (r_tstate[2]) begin
        bus.CEbar = 1'b0;
        bus.LIbar = 1'b0;
      end
      if (r_tstate[3]) begin
        case (bus.opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            bus.EIbar = 1'b0;
            bus.LMbar = 1'b0;
          end
          OP_OUT: begin
            bus.EA    = 1'b1;
            bus.LObar = 1'b0;
          end
          OP_JMP: begin
            bus.EIbar = 1'b0;
            bus.LPbar = 1'b0;
          end
          OP_JZ: begin
            bus.EIbar = ~bus.Zero;
            bus.LPbar = ~bus.Zero;
          end
          default: ;
        endcase
      end
      if (r_tstate[4]) begin
        case (bus.opcode)
          OP_LDA: begin
            bus.CEbar = 1'b0;
            bus.LAbar = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            bus.CEbar = 1'b0;
            bus.LBbar = 1'b0;
          end
          default: ;
        endcase
      end
      if (r_tstate[5]) begin
        case (bus.opcode)
          OP_ADD: begin
            bus.EU    = 1'b1;
            bus.LAbar = 1'b0;
          end
          OP_SUB: begin
            bus.EU    = 1'b1;
            bus.SU    = 1'b1;
            bus.LAbar = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.Halt   = (r_state == S_HALT);
  assign bus.Tstate = r_tstate;

endmodule

// File: tb/tb_sap_ctrl_seq_var.sv
// Bench for sap_ctrl_seq_var: RING_LEN=6 and RING_LEN=8 instances against a T-number reference model.
`timescale 1ns/1ps
module tb_sap_ctrl_seq_var;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0100;
  localparam logic [3:0] OP_JZ  = 4'b0101;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

`ifdef SAP_EARLY_END_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct packed {
    logic Cp, Ep, EA, SU, EU;
    logic LMbar, CEbar, LIbar, EIbar, LAbar, LBbar, LObar, LPbar;
  } cw_t;

  localparam cw_t IDLE = 13'b00000_11111111;
  localparam int  RL [2] = '{6, 8};

  logic       Clk    = 1'b0;
  logic       Clrbar = 1'b1;
  logic [3:0] op     = OP_LDA;
  logic       Zero   = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  int m_t [2] = '{1, 1};
  bit m_h [2] = '{1'b0, 1'b0};

  sap_ctrl_seq_var_if #(.RING_LEN(6)) bus6 ();
  sap_ctrl_seq_var_if #(.RING_LEN(8)) bus8 ();

  assign bus6.opcode = op;
  assign bus6.Zero   = Zero;
  assign bus8.opcode = op;
  assign bus8.Zero   = Zero;

  sap_ctrl_seq_var #(.RING_LEN(6)) dut6 (.Clk(Clk), .Clrbar(Clrbar), .bus(bus6));
  sap_ctrl_seq_var #(.RING_LEN(8)) dut8 (.Clk(Clk), .Clrbar(Clrbar), .bus(bus8));

  always #5 Clk = ~Clk;

  cw_t         act_cw [2];
  logic [15:0] act_ts [2];
  logic        act_h  [2];

  assign act_cw[0] = {bus6.Cp, bus6.Ep, bus6.EA, bus6.SU, bus6.EU, bus6.LMbar, bus6.CEbar,
                      bus6.LIbar, bus6.EIbar, bus6.LAbar, bus6.LBbar, bus6.LObar, bus6.LPbar};
  assign act_cw[1] = {bus8.Cp, bus8.Ep, bus8.EA, bus8.SU, bus8.EU, bus8.LMbar, bus8.CEbar,
                      bus8.LIbar, bus8.EIbar, bus8.LAbar, bus8.LBbar, bus8.LObar, bus8.LPbar};
  assign act_ts[0] = 16'(bus6.Tstate);
  assign act_ts[1] = 16'(bus8.Tstate);
  assign act_h[0]  = bus6.Halt;
  assign act_h[1]  = bus8.Halt;

  function automatic int last_of(input logic [3:0] o);
    if (o == OP_LDA) return 5;
    if (o == OP_ADD || o == OP_SUB) return 6;
    if (o == OP_OUT || o == OP_JMP || o == OP_JZ) return 4;
    return 3;
  endfunction

  // Micro-op table indexed by T number (1-based).
  function automatic cw_t exp_cw(input int t, input logic [3:0] o, input logic z,
                                 input bit h, input logic clr);
    cw_t c;
    c = IDLE;
    if (clr && !h) begin
      case (t)
        1: begin c.Ep = 1'b1; c.LMbar = 1'b0; end
        2: c.Cp = 1'b1;
        3: begin c.CEbar = 1'b0; c.LIbar = 1'b0; end
        4: begin
          if (o inside {OP_LDA, OP_ADD, OP_SUB}) begin c.EIbar = 1'b0; c.LMbar = 1'b0; end
          else if (o == OP_OUT) begin c.EA = 1'b1; c.LObar = 1'b0; end
          else if (o == OP_JMP || (o == OP_JZ && z)) begin c.EIbar = 1'b0; c.LPbar = 1'b0; end
        end
        5: begin
          if (o == OP_LDA) begin c.CEbar = 1'b0; c.LAbar = 1'b0; end
          else if (o == OP_ADD || o == OP_SUB) begin c.CEbar = 1'b0; c.LBbar = 1'b0; end
        end
        6: if (o == OP_ADD || o == OP_SUB) begin
          c.EU = 1'b1; c.LAbar = 1'b0; c.SU = (o == OP_SUB);
        end
        default: ;
      endcase
    end
    return c;
  endfunction

  always @(negedge Clk or negedge Clrbar) begin
    for (int i = 0; i < 2; i++) begin
      if (!Clrbar) begin
        m_t[i] <= 1;
        m_h[i] <= 1'b0;
      end else if (m_h[i]) begin
        m_t[i] <= m_t[i];
      end else if (m_t[i] == 3 && op == OP_HLT) begin
        m_h[i] <= 1'b1;
        m_t[i] <= 4;
      end else if (EARLY && m_t[i] == last_of(op)) begin
        m_t[i] <= 1;
      end else begin
        m_t[i] <= m_t[i] % RL[i] + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always begin
    @(posedge Clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("cw_rl%0d", RL[i]), 32'(act_cw[i]),
            32'(exp_cw(m_t[i], op, Zero, m_h[i], Clrbar)));
      check($sformatf("tstate_rl%0d", RL[i]), 32'(act_ts[i]), 32'(16'(1) << (m_t[i] - 1)));
      check($sformatf("halt_rl%0d", RL[i]), 32'(act_h[i]), 32'(m_h[i]));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic pulse_reset();
    Clrbar = 1'b0;
    #1;
    check("pulse_tstate", 32'(bus6.Tstate), 32'(6'b000001));
    check("pulse_cw", 32'(act_cw[0]), 32'(IDLE));
    Clrbar = 1'b1;
  endtask

  initial begin
    #1 Clrbar = 1'b0;
    #1;
    check("rst_tstate", 32'(bus6.Tstate), 32'(6'b000001));
    check("rst_cw6", 32'(act_cw[0]), 32'(IDLE));
    check("rst_cw8", 32'(act_cw[1]), 32'(IDLE));
    check("rst_halt", 32'(bus6.Halt), 0);
    #13 Clrbar = 1'b1;
    #1;
    check("lda_t1_Ep", 32'(bus6.Ep), 1);
    check("lda_t1_LMbar", 32'(bus6.LMbar), 0);
    tick(3);
    check("lda_t4_EIbar", 32'(bus6.EIbar), 0);
    check("lda_t4_LMbar", 32'(bus6.LMbar), 0);
    tick(1);
    check("lda_t5_CEbar", 32'(bus6.CEbar), 0);
    check("lda_t5_LAbar", 32'(bus6.LAbar), 0);
    tick(2);
    check("lda_wrap", 32'(bus6.Tstate), EARLY ? 32'(6'b000010) : 32'(6'b000001));

    #1 op = OP_SUB;
    pulse_reset();
    tick(4);
    check("sub_t5_SU", 32'(bus6.SU), 0);
    tick(1);
    check("sub_t6_SU", 32'(bus6.SU), 1);
    check("sub_t6_EU", 32'(bus6.EU), 1);
    check("sub_t6_LAbar", 32'(bus6.LAbar), 0);

    #1 op = OP_JZ;
    Zero = 1'b1;
    pulse_reset();
    tick(3);
    check("jz1_EIbar", 32'(bus6.EIbar), 0);
    check("jz1_LPbar", 32'(bus6.LPbar), 0);
    #1 Zero = 1'b0;
    #1;
    check("jz0_LPbar", 32'(bus6.LPbar), 1);
    check("jz0_cw", 32'(act_cw[0]), 32'(IDLE));

    op = OP_HLT;
    pulse_reset();
    tick(3);
    check("hlt_halt", 32'(bus6.Halt), 1);
    for (int k = 0; k < 20; k++) begin
      tick(1);
      check("hlt_freeze", 32'(bus6.Tstate), 32'(6'b001000));
    end
    #1;
    pulse_reset();
    check("hlt_clr_halt", 32'(bus6.Halt), 0);
    check("hlt_clr_tstate", 32'(bus6.Tstate), 32'(6'b000001));

    op = OP_OUT;
    pulse_reset();
    tick(3);
    check("out8_t4_EA", 32'(bus8.EA), 1);
    check("out8_t4_LObar", 32'(bus8.LObar), 0);
    tick(1);
    check("out8_after4", 32'(bus8.Tstate), EARLY ? 32'(8'b00000001) : 32'(8'b00010000));
    check("out8_after4_LObar", 32'(bus8.LObar), 1);
    tick(4);
    check("out8_after8", 32'(bus8.Tstate), 32'(8'b00000001));

    #1 op = OP_ADD;
    pulse_reset();
    tick(4);
    check("add_t5_LBbar", 32'(bus6.LBbar), 0);
    #1 Clrbar = 1'b0;
    #1;
    check("add_abort_LBbar", 32'(bus6.LBbar), 1);
    check("add_abort_CEbar", 32'(bus6.CEbar), 1);
    check("add_abort_tstate", 32'(bus6.Tstate), 32'(6'b000001));
    Clrbar = 1'b1;

    for (int k = 0; k < 600; k++) begin
      tick(1);
      #1;
      if ($urandom_range(0, 39) == 0) pulse_reset();
      if ($urandom_range(0, 3) == 0) begin
        op = 4'($urandom_range(0, 15));
        if (op == OP_HLT && $urandom_range(0, 3) != 0) op = OP_JZ;
      end
      Zero = 1'($urandom_range(0, 1));
    end

    tick(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
